// File: rtl/packet_checker.sv
// RX-side frame checker for the 10G loopback perf design: verifies the incrementing
// byte pattern, tkeep shape, frame length and MAC error flag of every received frame.
module packet_checker #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 10,
   parameter int CNT_W  = 32
) (
   input  logic                  i_rx_clk,
   input  logic                  i_rx_reset_n,
   // s_axis has no tready: every beat with tvalid high at a rising edge is consumed,
   // and tdata/tkeep/tlast/tuser are only looked at on such beats.
   input  logic                  s_axis_tvalid,
   input  logic [DATA_W-1:0]     s_axis_tdata,
   input  logic [DATA_W/8-1:0]   s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   input  logic [LEN_W-1:0]      i_vio_packet_bytes,
   output logic                  o_last_received,
   output logic                  o_pkt_ok,
   output logic [3:0]            o_err_flags,
   output logic [LEN_W:0]        o_rx_bytes,
   output logic [CNT_W-1:0]      o_packet_count,
   output logic [CNT_W-1:0]      o_error_count,
   output logic                  o_state_dbg
);

   localparam int KEEP_W  = DATA_W / 8;
   localparam int BYTES_W = LEN_W + 1;

   localparam logic [KEEP_W-1:0]  KEEP_ONE = KEEP_W'(1);
   localparam logic [KEEP_W-1:0]  KEEP_ALL = '1;
   localparam logic [BYTES_W-1:0] BYTE_ONE = BYTES_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_PAYLOAD = 1'b1
   } state_t;

   state_t               state_q;
   logic [BYTES_W-1:0]   bytes_q;
   logic [3:0]           flags_q;
   logic [LEN_W-1:0]     len_q;

   logic                 last_q;
   logic                 pkt_ok_q;
   logic [3:0]           err_flags_q;
   logic [BYTES_W-1:0]   rx_bytes_q;
   logic [CNT_W-1:0]     pkt_cnt_q;
   logic [CNT_W-1:0]     err_cnt_q;

   logic                 first_beat;
   logic [BYTES_W-1:0]   bytes_base;
   logic [3:0]           flags_base;
   logic [LEN_W-1:0]     len_cur;
   logic [BYTES_W-1:0]   beat_pop;
   logic                 data_err;
   logic                 keep_err;
   logic [BYTES_W:0]     bytes_sum;
   logic [BYTES_W-1:0]   bytes_d;
   logic                 len_err;
   logic [3:0]           flags_d;

   // A beat seen in S_IDLE starts a new frame, so it works from a clean byte count,
   // clean flags and a freshly captured expected length.
   always_comb begin
      first_beat = (state_q == S_IDLE);
      bytes_base = first_beat ? '0 : bytes_q;
      flags_base = first_beat ? 4'b0000 : flags_q;
      len_cur    = first_beat ? i_vio_packet_bytes : len_q;

      beat_pop = '0;
      data_err = 1'b0;
      for (int k = 0; k < KEEP_W; k++) begin
         if (s_axis_tkeep[k]) begin
            beat_pop = beat_pop + BYTE_ONE;
            if (s_axis_tdata[8*k +: 8] != (bytes_base[7:0] + 8'(k))) begin
               data_err = 1'b1;
            end
         end
      end

      // Low-aligned keep means keep+1 is a power of two, so keep & (keep+1) is zero.
      keep_err = (s_axis_tkeep == '0)
              || (!s_axis_tlast && (s_axis_tkeep != KEEP_ALL))
              || ((s_axis_tkeep & (s_axis_tkeep + KEEP_ONE)) != '0);

      bytes_sum = {1'b0, bytes_base} + {1'b0, beat_pop};
      bytes_d   = bytes_sum[BYTES_W] ? '1 : bytes_sum[BYTES_W-1:0];

      len_err = (len_cur != '0) && (bytes_d != {1'b0, len_cur});

      flags_d = flags_base | {s_axis_tlast & s_axis_tuser,
                              keep_err,
                              s_axis_tlast & len_err,
                              data_err};
   end

   always_ff @(posedge i_rx_clk) begin
      if (!i_rx_reset_n) begin
         state_q     <= S_IDLE;
         bytes_q     <= '0;
         flags_q     <= 4'b0000;
         len_q       <= '0;
         last_q      <= 1'b0;
         pkt_ok_q    <= 1'b0;
         err_flags_q <= 4'b0000;
         rx_bytes_q  <= '0;
         pkt_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         last_q <= s_axis_tvalid && s_axis_tlast;
         if (s_axis_tvalid) begin
            bytes_q <= bytes_d;
            flags_q <= flags_d;
            len_q   <= len_cur;
            if (s_axis_tlast) begin
               state_q     <= S_IDLE;
               err_flags_q <= flags_d;
               pkt_ok_q    <= (flags_d == 4'b0000);
               rx_bytes_q  <= bytes_d;
               if (pkt_cnt_q != '1) begin
                  pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
               end
               if ((flags_d != 4'b0000) && (err_cnt_q != '1)) begin
                  err_cnt_q <= err_cnt_q + CNT_ONE;
               end
            end else begin
               state_q <= S_PAYLOAD;
            end
         end
      end
   end

   assign o_last_received = last_q;
   assign o_pkt_ok        = pkt_ok_q;
   assign o_err_flags     = err_flags_q;
   assign o_rx_bytes      = rx_bytes_q;
   assign o_packet_count  = pkt_cnt_q;
   assign o_error_count   = err_cnt_q;
   assign o_state_dbg     = state_q;

endmodule
